// File: rtl/pc_ctrl_if.sv
//------------------------------------------------------------------------------
// pc_ctrl_if
//   Bundles the run-control, decode and ALU-result signals of the PC stage.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_ctrl_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic [4:0]      op;
    logic            halt;
    logic            stall;
    logic [7:0]      alu_rslt;
    logic            alu_co;
    logic            alu_lt;
    logic            alu_z;
    logic [PC_W-1:0] pc;
    logic            branch_taken;
    logic            flag_z;
    logic            flag_lt;
    logic            flag_co;
    logic            running;
    logic            done;

    modport master (
        output start, op, halt, stall, alu_rslt, alu_co, alu_lt, alu_z,
        input  pc, branch_taken, flag_z, flag_lt, flag_co, running, done
    );

    modport slave (
        input  start, op, halt, stall, alu_rslt, alu_co, alu_lt, alu_z,
        output pc, branch_taken, flag_z, flag_lt, flag_co, running, done
    );
endinterface

`default_nettype wire

// File: rtl/pc_ctrl.sv
//------------------------------------------------------------------------------
// pc_ctrl
//   Program counter, architectural flags, branch resolution and run control.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_ctrl #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pc_ctrl_if.slave   bus
);
    localparam logic [4:0] c_OP_ADD = 5'd0;
    localparam logic [4:0] c_OP_CMP = 5'd5;
    localparam logic [4:0] c_OP_BE  = 5'd9;
    localparam logic [4:0] c_OP_BL  = 5'd10;
    localparam logic [4:0] c_OP_BG  = 5'd11;
    localparam logic [4:0] c_OP_BA  = 5'd12;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    localparam logic [PC_W-1:0] c_START  = PC_W'(START_PC);
    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_flag_z;
    logic            r_flag_lt;
    logic            r_flag_co;

    logic            w_advance;
    logic            w_cond;
    logic            w_branch_taken;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_pc_next;

    assign w_advance = ~bus.stall;

    // Branch offset is an 8-bit two's-complement value sign-extended to PC_W.
    if (PC_W > 8) begin : g_sext_wide
        assign w_offset = {{(PC_W-8){bus.alu_rslt[7]}}, bus.alu_rslt};
    end else begin : g_sext_narrow
        assign w_offset = bus.alu_rslt[PC_W-1:0];
    end

    // Conditions look only at registered flags, never at this cycle's ALU outputs.
    always_comb begin
        w_cond = 1'b0;
        case (bus.op)
            c_OP_BE: w_cond = r_flag_z;
            c_OP_BL: w_cond = r_flag_lt;
            c_OP_BG: w_cond = ~r_flag_z & ~r_flag_lt;
            c_OP_BA: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_branch_taken = (r_state == c_ST_RUN) & w_cond;
    assign w_pc_next      = w_branch_taken ? (r_pc + w_offset) : (r_pc + c_PC_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= c_START;
            r_flag_z  <= 1'b0;
            r_flag_lt <= 1'b0;
            r_flag_co <= 1'b0;
        end else if (w_advance) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_pc <= c_START;
                    if (bus.start) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (bus.halt) begin
                        r_state <= c_ST_HALT;
                    end else begin
                        r_pc <= w_pc_next;
                        if (bus.op == c_OP_CMP) begin
                            r_flag_z  <= bus.alu_z;
                            r_flag_lt <= bus.alu_lt;
                        end
                        if (bus.op == c_OP_ADD) begin
                            r_flag_co <= bus.alu_co;
                        end
                    end
                end
                c_ST_HALT: begin
                    // Restart begins a fresh program: PC and flags return to reset values.
                    if (bus.start) begin
                        r_state   <= c_ST_RUN;
                        r_pc      <= c_START;
                        r_flag_z  <= 1'b0;
                        r_flag_lt <= 1'b0;
                        r_flag_co <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_pc    <= c_START;
                end
            endcase
        end
    end

    assign bus.pc           = r_pc;
    assign bus.branch_taken = w_branch_taken;
    assign bus.flag_z       = r_flag_z;
    assign bus.flag_lt      = r_flag_lt;
    assign bus.flag_co      = r_flag_co;
    assign bus.running      = (r_state == c_ST_RUN);
    assign bus.done         = (r_state == c_ST_HALT);
endmodule

`default_nettype wire
